// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and bit counter width.
package i2c_pkg;

    localparam int BIT_CNT_SZ = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_t;

endpackage

// File: rtl/i2c_slave_if.sv
// Local-side handshake between the I2C slave and the logic it serves.
interface i2c_slave_if #(
    parameter int DATA_SZ = 8
);
    logic [DATA_SZ-1:0] data_rd;
    logic [DATA_SZ-1:0] data_wr;
    logic               wr_vld;
    logic               rd_req;
    logic               busy;

    modport slave (
        input  data_rd,
        output data_wr, wr_vld, rd_req, busy
    );

    modport master (
        output data_rd,
        input  data_wr, wr_vld, rd_req, busy
    );
endinterface

// File: rtl/i2c_slave_sync.sv
// SCL/SDA synchronisers with edge, START and STOP detection.
module i2c_slave_sync (
    input  logic CLK,
    input  logic RST_n,
    input  logic I_SCL,
    input  logic I_SDA,
    output logic O_SCL,
    output logic O_SDA,
    output logic O_SCL_RS,
    output logic O_SCL_FL,
    output logic O_START,
    output logic O_STOP
);
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_hist;
    logic       sda_hist;

    // Two-flop synchronisers plus a history flop; reset to the idle-high bus level
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], I_SCL};
            sda_sync <= {sda_sync[0], I_SDA};
            scl_hist <= scl_sync[1];
            sda_hist <= sda_sync[1];
        end
    end

    assign O_SCL    = scl_sync[1];
    assign O_SDA    = sda_sync[1];
    assign O_SCL_RS = scl_sync[1] & ~scl_hist;
    assign O_SCL_FL = ~scl_sync[1] & scl_hist;
    assign O_START  = scl_sync[1] & scl_hist & ~sda_sync[1] & sda_hist;
    assign O_STOP   = scl_sync[1] & scl_hist & sda_sync[1] & ~sda_hist;

endmodule

// File: rtl/i2c_slave.sv
// I2C target answering one 7-bit address; write bytes strobed out, read bytes requested.
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_IDLE      | bus free or not yet addressed
// ST_ADDR      | shifting in address + R/W
// ST_ADDR_ACK  | driving ACK for a matched address
// ST_WR_DATA   | shifting in a write byte
// ST_WR_ACK    | driving ACK for a write byte
// ST_RD_DATA   | shifting out a read byte
// ST_RD_ACK    | sampling master ACK/NACK
// ST_WAIT_STOP | not addressed or NACKed; wait for START/STOP
module i2c_slave
    import i2c_pkg::*;
#(
    parameter int                 ADDR_SZ    = 7,
    parameter int                 DATA_SZ    = 8,
    parameter logic [ADDR_SZ-1:0] SLAVE_ADDR = 7'h50
) (
    input  logic       CLK,
    input  logic       RST_n,
    inout  wire        IO_SCL,
    inout  wire        IO_SDA,
    i2c_slave_if.slave host
);
    localparam logic [BIT_CNT_SZ-1:0] LAST_BIT = BIT_CNT_SZ'(DATA_SZ - 1);

    logic scl, sda, scl_rs, scl_fl, start, stop;

    i2c_slave_sync u_sync (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .I_SCL    (IO_SCL),
        .I_SDA    (IO_SDA),
        .O_SCL    (scl),
        .O_SDA    (sda),
        .O_SCL_RS (scl_rs),
        .O_SCL_FL (scl_fl),
        .O_START  (start),
        .O_STOP   (stop)
    );

    i2c_state_t              state;
    logic [BIT_CNT_SZ-1:0]   bit_cnt;
    // Only DATA_SZ-1 bits are stored: the last incoming bit comes straight from sda,
    // and the outgoing MSB is driven straight from data_rd when loading.
    logic [DATA_SZ-2:0]      shreg;
    logic                    rw;
    logic                    ack_pend;
    logic                    sda_low;
    logic [DATA_SZ-1:0]      byte_in;
    logic                    bit_clk;

    assign byte_in = {shreg, sda};
    assign bit_clk = scl_rs & scl;

    // Protocol FSM with shift register, bit counter and registered outputs
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            rw           <= 1'b0;
            ack_pend     <= 1'b0;
            sda_low      <= 1'b0;
            host.data_wr <= '0;
            host.wr_vld  <= 1'b0;
            host.rd_req  <= 1'b0;
            host.busy    <= 1'b0;
        end else begin
            host.wr_vld <= 1'b0;
            host.rd_req <= 1'b0;
            if (stop) begin
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                ack_pend <= 1'b0;
                sda_low  <= 1'b0;
                host.busy <= 1'b0;
            end else if (start) begin
                state    <= ST_ADDR;
                bit_cnt  <= '0;
                ack_pend <= 1'b0;
                sda_low  <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (bit_clk) begin
                            shreg   <= byte_in[DATA_SZ-2:0];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                if (byte_in[DATA_SZ-1 -: ADDR_SZ] == SLAVE_ADDR) begin
                                    ack_pend <= 1'b1;
                                    rw       <= sda;
                                end else begin
                                    host.busy <= 1'b0;
                                    state     <= ST_WAIT_STOP;
                                end
                            end
                        end else if (scl_fl && ack_pend) begin
                            ack_pend    <= 1'b0;
                            sda_low     <= 1'b1;
                            host.busy   <= 1'b1;
                            host.rd_req <= rw;
                            state       <= ST_ADDR_ACK;
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fl) begin
                            if (rw) begin
                                shreg   <= host.data_rd[DATA_SZ-2:0];
                                sda_low <= ~host.data_rd[DATA_SZ-1];
                                state   <= ST_RD_DATA;
                            end else begin
                                sda_low <= 1'b0;
                                state   <= ST_WR_DATA;
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (bit_clk) begin
                            shreg   <= byte_in[DATA_SZ-2:0];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                host.data_wr <= byte_in;
                                host.wr_vld  <= 1'b1;
                                ack_pend     <= 1'b1;
                            end
                        end else if (scl_fl && ack_pend) begin
                            ack_pend <= 1'b0;
                            sda_low  <= 1'b1;
                            state    <= ST_WR_ACK;
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fl) begin
                            sda_low <= 1'b0;
                            state   <= ST_WR_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_fl) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                sda_low <= 1'b0;
                                state   <= ST_RD_ACK;
                            end else begin
                                sda_low <= ~shreg[DATA_SZ-2];
                                shreg   <= {shreg[DATA_SZ-3:0], 1'b0};
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (bit_clk) begin
                            if (!sda) begin
                                host.rd_req <= 1'b1;
                                ack_pend    <= 1'b1;
                            end else begin
                                host.busy <= 1'b0;
                                state     <= ST_WAIT_STOP;
                            end
                        end else if (scl_fl && ack_pend) begin
                            ack_pend <= 1'b0;
                            shreg    <= host.data_rd[DATA_SZ-2:0];
                            sda_low  <= ~host.data_rd[DATA_SZ-1];
                            state    <= ST_RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign IO_SDA = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a simple bit-banged master drives the bus.
module tb_i2c_slave;

    localparam int Q = 10;   // quarter of a bit in CLK
    localparam int H = 20;   // SCL high/low time in CLK

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m_scl_low = 1'b0;
    logic m_sda_low = 1'b0;

    wire scl;
    wire sda;
    pullup (scl);
    pullup (sda);
    assign scl = m_scl_low ? 1'b0 : 1'bz;
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave_if #(.DATA_SZ(8)) hif ();

    i2c_slave #(
        .ADDR_SZ    (7),
        .DATA_SZ    (8),
        .SLAVE_ADDR (7'h50)
    ) dut (
        .CLK    (clk),
        .RST_n  (rst_n),
        .IO_SCL (scl),
        .IO_SDA (sda),
        .host   (hif)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] rd_bytes [4] = '{8'h3C, 8'hC3, 8'h77, 8'h00};
    logic [1:0] rd_idx = 2'd0;
    int rd_req_cnt = 0;
    int wr_cnt = 0;
    int drive_cnt = 0;
    int busy_cnt = 0;
    int busy_gap = 0;
    logic watch_busy = 1'b0;

    // Local-logic model: serves read bytes on request and counts strobes/bus activity
    always @(negedge clk) begin
        if (!rst_n) begin
            hif.data_rd = 8'h00;
        end else if (hif.rd_req) begin
            hif.data_rd = rd_bytes[rd_idx];
            rd_idx = rd_idx + 2'd1;
            rd_req_cnt++;
        end
        if (hif.wr_vld) wr_cnt++;
        if (sda === 1'b0 && !m_sda_low) drive_cnt++;
        if (hif.busy) busy_cnt++;
        if (watch_busy && !hif.busy) busy_gap++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        wait_clk(Q); m_sda_low = 1'b0;
        wait_clk(Q); m_scl_low = 1'b0;
        wait_clk(H); m_sda_low = 1'b1;
        wait_clk(H); m_scl_low = 1'b1;
    endtask

    task automatic bus_stop();
        wait_clk(Q); m_sda_low = 1'b1;
        wait_clk(Q); m_scl_low = 1'b0;
        wait_clk(H); m_sda_low = 1'b0;
        wait_clk(H);
    endtask

    task automatic write_bit(input logic b);
        wait_clk(Q); m_sda_low = ~b;
        wait_clk(Q); m_scl_low = 1'b0;
        wait_clk(H); m_scl_low = 1'b1;
    endtask

    task automatic read_bit(output logic b);
        wait_clk(Q); m_sda_low = 1'b0;
        wait_clk(Q); m_scl_low = 1'b0;
        wait_clk(H / 2);
        @(negedge clk); b = sda;
        wait_clk(H / 2); m_scl_low = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic bv;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bv);
            d[i] = bv;
        end
    endtask

    task automatic test_reset();
        wait_clk(3);
        @(negedge clk);
        checks++; if (hif.data_wr !== 8'h00) begin errors++; $display("FAIL reset_data_wr: got %h want 00", hif.data_wr); end
        checks++; if (hif.wr_vld !== 1'b0) begin errors++; $display("FAIL reset_wr_vld: got %b want 0", hif.wr_vld); end
        checks++; if (hif.rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b want 0", hif.rd_req); end
        checks++; if (hif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", hif.busy); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda); end
        rst_n = 1'b1;
        wait_clk(10);
        @(negedge clk);
        checks++; if (hif.busy !== 1'b0 || sda !== 1'b1) begin errors++; $display("FAIL post_reset_idle: busy %b sda %b want 0 1", hif.busy, sda); end
    endtask

    task automatic test_write();
        logic ack;
        int wr0;
        wr0 = wr_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b want 0", ack); end
        checks++; if (hif.busy !== 1'b1) begin errors++; $display("FAIL wr_busy_set: got %b want 1", hif.busy); end
        write_byte(8'hA5, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_data_ack: got %b want 0", ack); end
        checks++; if (wr_cnt - wr0 !== 1) begin errors++; $display("FAIL wr_vld_cycles: got %0d want 1", wr_cnt - wr0); end
        checks++; if (hif.data_wr !== 8'hA5) begin errors++; $display("FAIL wr_data: got %h want a5", hif.data_wr); end
        checks++; if (hif.busy !== 1'b1) begin errors++; $display("FAIL wr_busy_before_stop: got %b want 1", hif.busy); end
        bus_stop();
        @(negedge clk);
        checks++; if (hif.busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop: got %b want 0", hif.busy); end
    endtask

    task automatic test_read_two();
        logic ack;
        logic [7:0] d;
        int rq0;
        rq0 = rd_req_cnt;
        bus_start();
        write_byte(8'hA1, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
        read_byte(d);
        checks++; if (d !== 8'h3C) begin errors++; $display("FAIL rd_byte0: got %h want 3c", d); end
        write_bit(1'b0);
        read_byte(d);
        checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rd_byte1: got %h want c3", d); end
        write_bit(1'b1);
        @(negedge clk);
        checks++; if (hif.busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after_nack: got %b want 0", hif.busy); end
        // Extra clocks in WAIT_STOP must leave SDA alone
        read_byte(d);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL rd_wait_stop_sda: got %h want ff", d); end
        checks++; if (rd_req_cnt - rq0 !== 2) begin errors++; $display("FAIL rd_req_count: got %0d want 2", rd_req_cnt - rq0); end
        bus_stop();
    endtask

    task automatic test_mismatch();
        logic ack;
        int wr0, rq0, dr0, bz0;
        wr0 = wr_cnt; rq0 = rd_req_cnt; dr0 = drive_cnt; bz0 = busy_cnt;
        bus_start();
        write_byte(8'hA2, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mm_addr_nack: got %b want 1", ack); end
        write_byte(8'h5A, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mm_data_nack: got %b want 1", ack); end
        bus_stop();
        checks++; if (drive_cnt - dr0 !== 0) begin errors++; $display("FAIL mm_sda_driven: got %0d cycles want 0", drive_cnt - dr0); end
        checks++; if (wr_cnt - wr0 !== 0 || rd_req_cnt - rq0 !== 0) begin errors++; $display("FAIL mm_strobes: wr %0d rd %0d want 0 0", wr_cnt - wr0, rd_req_cnt - rq0); end
        checks++; if (busy_cnt - bz0 !== 0) begin errors++; $display("FAIL mm_busy: got %0d cycles want 0", busy_cnt - bz0); end
    endtask

    task automatic test_rep_start();
        logic ack;
        logic [7:0] d;
        int wr0;
        wr0 = wr_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h10, ack);
        checks++; if (ack !== 1'b0 || wr_cnt - wr0 !== 1 || hif.data_wr !== 8'h10) begin errors++; $display("FAIL rs_write: ack %b vld %0d data %h want 0 1 10", ack, wr_cnt - wr0, hif.data_wr); end
        watch_busy = 1'b1;
        bus_start();
        write_byte(8'hA1, ack);
        watch_busy = 1'b0;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_addr_ack: got %b want 0", ack); end
        checks++; if (busy_gap !== 0) begin errors++; $display("FAIL rs_busy_gap: got %0d cycles want 0", busy_gap); end
        read_byte(d);
        checks++; if (d !== 8'h77) begin errors++; $display("FAIL rs_read: got %h want 77", d); end
        write_bit(1'b1);
        bus_stop();
    endtask

    task automatic test_abort();
        logic ack;
        int wr0;
        wr0 = wr_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        bus_stop();
        @(negedge clk);
        checks++; if (wr_cnt - wr0 !== 0) begin errors++; $display("FAIL ab_wr_vld: got %0d want 0", wr_cnt - wr0); end
        checks++; if (hif.data_wr !== 8'h10) begin errors++; $display("FAIL ab_data_hold: got %h want 10", hif.data_wr); end
        checks++; if (hif.busy !== 1'b0) begin errors++; $display("FAIL ab_busy: got %b want 0", hif.busy); end
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h3E, ack);
        bus_stop();
        checks++; if (ack !== 1'b0 || hif.data_wr !== 8'h3E) begin errors++; $display("FAIL ab_recover: ack %b data %h want 0 3e", ack, hif.data_wr); end
    endtask

    task automatic test_reset_mid();
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 5);
        wait_clk(Q); m_sda_low = 1'b0;
        wait_clk(Q); m_scl_low = 1'b0;
        wait_clk(Q);
        @(negedge clk);
        checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rm_ack_driven: got %b want 0", sda); end
        rst_n = 1'b0;
        #1;
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rm_sda_release: got %b want 1", sda); end
        checks++; if (hif.busy !== 1'b0 || hif.data_wr !== 8'h00 || hif.wr_vld !== 1'b0 || hif.rd_req !== 1'b0) begin
            errors++; $display("FAIL rm_outputs: busy %b data %h vld %b req %b want 0 00 0 0", hif.busy, hif.data_wr, hif.wr_vld, hif.rd_req);
        end
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(10);
        @(negedge clk);
        checks++; if (sda !== 1'b1 || hif.busy !== 1'b0) begin errors++; $display("FAIL rm_after_release: sda %b busy %b want 1 0", sda, hif.busy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_two();
        test_mismatch();
        test_rep_start();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
